// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge. Request/response fields use the
// widest supported bus so one type set serves every APB_AW/APB_DW build.
package apb_master_pkg;

  localparam int ADDR_W_MAX = 64;
  localparam int DATA_W_MAX = 64;
  localparam int STRB_W_MAX = DATA_W_MAX / 8;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] wdata;
    logic [STRB_W_MAX-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [DATA_W_MAX-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; the bridge drives it through the Master modport.
interface APB #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pwrite;
  logic            psel;
  logic            penable;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait-state counter (built only with APB_MASTER_TIMEOUT_EN).
// expired flags the wait cycle in which the count reaches LIMIT.
module apb_master_timeout #(
  parameter int LIMIT = 256
) (
  input  logic pclk,
  input  logic prst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_d == CW'(LIMIT));

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one valid/ready request -> SETUP/ACCESS -> valid/ready response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel=1, penable=0, one cycle
// ACCESS | psel=1, penable=1, waiting for pready
// RESP   | resp_valid high until resp_ready
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_AW         = 32,
  parameter int APB_DW         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [APB_AW-1:0]   req_addr,
  input  logic [APB_DW-1:0]   req_wdata,
  input  logic [APB_DW/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [APB_DW-1:0]   resp_rdata,
  output logic                resp_err,
  APB.Master                  m_apb
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  resp_t  resp_q, resp_d;
  logic   req_ready_q, req_ready_d;
  logic   resp_valid_q, resp_valid_d;
  logic   psel_q, psel_d;
  logic   penable_q, penable_d;
  logic   accept;
  logic   wait_expired;

  assign accept = req_valid && req_ready_q;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk    (pclk),
    .prst_n  (prst_n),
    .clr     (accept),
    .en      ((state_q == ACCESS) && !m_apb.pready),
    .expired (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_d       = resp_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_d.write = req_write;
          req_d.addr  = ADDR_W_MAX'(req_addr);
          req_d.wdata = DATA_W_MAX'(req_wdata);
          req_d.wstrb = req_write ? STRB_W_MAX'(req_wstrb) : '0;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout landing in the same cycle
        if (m_apb.pready) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d.err   = m_apb.pslverr;
          resp_d.rdata = (req_q.write || m_apb.pslverr) ? '0 : DATA_W_MAX'(m_apb.prdata);
          state_d      = RESP;
        end else if (wait_expired) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d.err   = 1'b1;
          resp_d.rdata = '0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_d       = '0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = APB_DW'(resp_q.rdata);
  assign resp_err      = resp_q.err;

  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.paddr   = APB_AW'(req_q.addr);
  assign m_apb.pwrite  = req_q.write;
  assign m_apb.pwdata  = APB_DW'(req_q.wdata);
  assign m_apb.pstrb   = (APB_DW/8)'(req_q.wstrb);
  assign m_apb.pprot   = PPROT_DEFAULT;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: cycle-exact APB phase checks and a
// response scoreboard. Timeout steps run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic        pclk;
  logic        prst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  APB #(.AW(32), .DW(32)) apb ();

  apb_master_bridge #(
    .APB_AW(32),
    .APB_DW(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk       (pclk),
    .prst_n     (prst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_apb      (apb)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st);
    chk("acc_psel", 64'(apb.psel), 64'(1'b1));
    chk("acc_penable", 64'(apb.penable), 64'(1'b1));
    chk("acc_paddr", 64'(apb.paddr), 64'(a));
    chk("acc_pwrite", 64'(apb.pwrite), 64'(w));
    chk("acc_pstrb", 64'(apb.pstrb), 64'(w ? st : 4'h0));
    if (w) chk("acc_pwdata", 64'(apb.pwdata), 64'(wd));
    chk("acc_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("acc_req_ready", 64'(req_ready), 64'(1'b0));
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = st;
    chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
    step();
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    chk("setup_psel", 64'(apb.psel), 64'(1'b1));
    chk("setup_penable", 64'(apb.penable), 64'(1'b0));
    chk("setup_paddr", 64'(apb.paddr), 64'(a));
    chk("setup_pwrite", 64'(apb.pwrite), 64'(w));
    chk("setup_pstrb", 64'(apb.pstrb), 64'(w ? st : 4'h0));
    if (w) chk("setup_pwdata", 64'(apb.pwdata), 64'(wd));
    chk("setup_req_ready", 64'(req_ready), 64'(1'b0));
  endtask

  // Response phase: hold resp_ready low for 'hold' cycles, compare against the scoreboard.
  task automatic take_resp(input int hold);
    exp_t e;
    chk("resp_valid", 64'(resp_valid), 64'(1'b1));
    chk("resp_psel_drop", 64'(apb.psel), 64'(1'b0));
    chk("resp_penable_drop", 64'(apb.penable), 64'(1'b0));
    chk("sb_nonempty", 64'(sb.size() > 0), 64'(1'b1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      apb.pready  = 1'b0;
      apb.prdata  = ~e.rdata;
      apb.pslverr = ~e.err;
      for (int h = 0; h <= hold; h++) begin
        chk("resp_hold_valid", 64'(resp_valid), 64'(1'b1));
        chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        chk("resp_err", 64'(resp_err), 64'(e.err));
        chk("resp_req_ready", 64'(req_ready), 64'(1'b0));
        chk("resp_psel_idle", 64'(apb.psel), 64'(1'b0));
        if (h < hold) step();
      end
    end
    apb.pslverr = 1'b0;
    resp_ready  = 1'b1;
    step();
    chk("post_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("post_req_ready", 64'(req_ready), 64'(1'b1));
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int nwait, input logic [31:0] rd,
                      input logic serr, input int hold);
    exp_t e;
    e.err   = serr;
    e.rdata = (w || serr) ? 32'h0 : rd;
    sb.push_back(e);
    apb.pready  = (nwait == 0);
    apb.prdata  = rd;
    apb.pslverr = serr;
    resp_ready  = (hold == 0);
    drive_req(w, a, wd, st);
    for (int i = 0; i <= nwait; i++) begin
      step();
      chk_access(w, a, wd, st);
      if (i == nwait) apb.pready = 1'b1;
    end
    step();
    take_resp(hold);
  endtask

  initial begin
    prst_n      = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    resp_ready  = 1'b1;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;

    step();
    step();
    chk("rst_psel", 64'(apb.psel), 64'(1'b0));
    chk("rst_penable", 64'(apb.penable), 64'(1'b0));
    chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(32'h0));
    chk("rst_paddr", 64'(apb.paddr), 64'(32'h0));
    chk("rst_pprot", 64'(apb.pprot), 64'(3'b000));
    prst_n = 1'b1;
    step();
    chk("rel_req_ready", 64'(req_ready), 64'(1'b1));

    // Zero-wait write
    xfer(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // Read with 3 wait states (4 ACCESS cycles)
    xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
    // Slave error on read zeroes rdata
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 1'b1, 0);
    // Slave error on write
    xfer(1'b1, 32'h0000_2004, 32'h5555_AAAA, 4'h3, 0, 32'h0, 1'b1, 0);
    // Backpressured response, then back-to-back request
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 5);
    xfer(1'b1, 32'h0000_3008, 32'h0BAD_1DEA, 4'h5, 2, 32'h0, 1'b0, 0);
    chk("pprot_const", 64'(apb.pprot), 64'(3'b000));

    for (int k = 0; k < 4; k++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
           $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset during ACCESS: bus drops at once, no response afterwards
    apb.pready = 1'b0;
    drive_req(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    step();
    chk_access(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    #2 prst_n = 1'b0;
    #1;
    chk("arst_psel", 64'(apb.psel), 64'(1'b0));
    chk("arst_penable", 64'(apb.penable), 64'(1'b0));
    chk("arst_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("arst_req_ready", 64'(req_ready), 64'(1'b0));
    step();
    prst_n = 1'b1;
    apb.pready = 1'b1;
    step();
    chk("arst_rel_req_ready", 64'(req_ready), 64'(1'b1));
    for (int c = 0; c < 4; c++) begin
      chk("arst_no_resp", 64'(resp_valid), 64'(1'b0));
      chk("arst_no_psel", 64'(apb.psel), 64'(1'b0));
      step();
    end
    apb.pready = 1'b0;

    // Post-reset transfer still works
    xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 1, 32'h7777_0001, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      sb.push_back(e);
      apb.pready = 1'b0;
      apb.prdata = 32'h1111_2222;
      resp_ready = 1'b1;
      drive_req(1'b0, 32'h0000_6000, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
        step();
        chk_access(1'b0, 32'h0000_6000, 32'h0, 4'h0);
      end
      step();
      take_resp(0);
    end
    // pready on the 4th ACCESS cycle beats the limit
    xfer(1'b0, 32'h0000_6004, 32'h0, 4'h0, 3, 32'h3333_4444, 1'b0, 0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator end of the peripheral APB bus.
- Accepts single read/write requests from the core-side memory port over a valid/ready handshake.
- Runs the APB SETUP/ACCESS sequence on an `APB.Master` interface, which feeds the peripheral subsystem's slave port.
- Returns read data and slave error on a valid/ready response channel; one transfer outstanding at a time.

Parameters:
- APB_AW, 32, APB address width.
- APB_DW, 32, APB data width; must be 32 or 64.
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles before abort; used only with APB_MASTER_TIMEOUT_EN; must be ≥ 2.

Ports:
- pclk  input  1  APB clock; single clock domain.
- prst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  APB_AW  byte address, passed unchanged to paddr.
- req_wdata  input  APB_DW  write data.
- req_wstrb  input  APB_DW/8  byte strobes; forced to 0 on reads.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumed when resp_valid && resp_ready.
- resp_rdata  output  APB_DW  read data; 0 for writes and errors.
- resp_err  output  1  pslverr or timeout.
- m_apb  interface  APB.Master  paddr/pwdata/pwrite/psel/penable/pstrb/pprot out; prdata/pready/pslverr in.

Behaviour:
- Reset: all outputs to 0 asynchronously, with two exceptions:
  - req_ready = 1 after reset release.
  - pprot is constant 3'b000.
- Reset mid-transfer: psel/penable drop immediately; the in-flight request is lost; no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, register addr/wdata/write/strb and go to SETUP.
  - req_ready is 0 in every other state; no new request until the response handshake completes.
- SETUP:
  - psel = 1, penable = 0, paddr/pwrite/pwdata/pstrb driven from the registers.
  - Exactly one cycle, then ACCESS.
- ACCESS:
  - psel = 1, penable = 1; all address/control/data held stable.
  - Each cycle pready = 0: stay, wait-state counter += 1.
  - pready = 1:
    - resp_rdata = prdata for reads, 0 for writes.
    - resp_err = pslverr. On error, resp_rdata = 0.
    - psel/penable drop next cycle; go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata/resp_err held stable until resp_ready.
  - On handshake go to IDLE; resp_valid drops the next cycle.
- Latency, zero wait states, resp_ready tied 1:
  - Accept at cycle T.
  - SETUP at T+1, ACCESS at T+2, resp_valid at T+3, next request accepted at T+4.
- pready/pslverr are ignored outside ACCESS.
- Wait-state counter: width $clog2(TIMEOUT_CYCLES+1); saturates; cleared on entry to SETUP.
- Never more than one psel cycle with penable = 0 per transfer.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - In ACCESS, if pready is still 0 when the counter reaches TIMEOUT_CYCLES, abort: psel/penable drop next cycle.
  - Go to RESP with resp_err = 1 and resp_rdata = 0.
  - A pready arriving in the same cycle as the limit wins: normal completion.
- Undefined:
  - Counter logic is removed; ACCESS waits indefinitely for pready.

Decomposition:
- apb_master_pkg holds:
  - state_e enum {IDLE, SETUP, ACCESS, RESP};
  - req_t packed struct {write, addr, wdata, wstrb};
  - resp_t packed struct {rdata, err};
  - localparam PPROT_DEFAULT = 3'b000.
- Sub-module apb_master_timeout: wait-state counter, clear/enable inputs, expired output; instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0xA5A5_0001 to 0x0000_1004, wstrb 4'hF, slave pready = 1 immediately:
  - SETUP at T+1 with paddr 0x1004, pwrite 1, pstrb F;
  - ACCESS at T+2;
  - resp_valid at T+3 with err 0, rdata 0.
- Read 0x0000_1000, slave inserts 3 wait states, prdata 0x1234_5678:
  - paddr/psel held for 4 ACCESS cycles;
  - resp_rdata 0x1234_5678 at T+6.
- Read with pslverr = 1 and prdata 0xFFFF_FFFF:
  - resp_err 1, resp_rdata 0.
- resp_ready held 0 for 5 cycles after resp_valid:
  - resp stable throughout;
  - req_ready 0 throughout;
  - a new request is accepted on the cycle after the response handshake.
- prst_n asserted during ACCESS:
  - psel/penable/resp_valid go 0 asynchronously;
  - req_ready 1 after release;
  - no response is issued.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4, pready never asserted:
  - abort after 4 ACCESS cycles;
  - resp_err 1, resp_rdata 0.
  - Repeat with pready on the 4th cycle → normal completion, err 0.
